// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Central sequencer for a 5-stage RV32I pipeline. Resolves
//                stall requests and taken branches into per-boundary halt
//                codes, discard strobes and PC hold/redirect controls.
//                Tracks wrong-path fetches in flight across a redirect and
//                runs a sticky stall watchdog.
//                Optional macro PIPE_CTRL_PERF_EN adds the performance
//                counters (stall cycles, flushes); without it both ports
//                read constant zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
    parameter int unsigned MAX_STALL = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_stall_req,
    input  logic        id_stall_req,
    input  logic        mem_stall_req,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_branch_target,
    output logic        pc_hold,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic [1:0]  ifid_halt,
    output logic [1:0]  idex_halt,
    output logic [1:0]  exmem_halt,
    output logic [1:0]  memwb_halt,
    output logic        ifid_discard,
    output logic        idex_discard,
    output logic        stall_timeout,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flushes
);

    localparam logic [1:0]  HALT_ADVANCE = 2'b00;
    localparam logic [1:0]  HALT_BUBBLE  = 2'b10;
    localparam logic [1:0]  HALT_HOLD    = 2'b11;
    localparam logic [15:0] CNT_MAX      = 16'(MAX_STALL);

    logic        kill_pend;
    logic        kill_next;
    logic        stall_sel;
    logic [15:0] stall_cnt;
    logic        wd_stall;

    // Watchdog only counts stalls waiting on memory/fetch, not load-use hazards
    assign wd_stall = if_stall_req | mem_stall_req;

    // Priority resolution of hazards into pipeline control, zero-cycle reaction
    always_comb begin
        pc_hold      = 1'b0;
        pc_redirect  = 1'b0;
        redirect_pc  = 32'h0;
        ifid_halt    = HALT_ADVANCE;
        idex_halt    = HALT_ADVANCE;
        exmem_halt   = HALT_ADVANCE;
        memwb_halt   = HALT_ADVANCE;
        ifid_discard = 1'b0;
        idex_discard = 1'b0;
        kill_next    = kill_pend;
        stall_sel    = 1'b0;

        if (!rst) begin
            pc_hold      = 1'b1;
            ifid_halt    = HALT_BUBBLE;
            idex_halt    = HALT_BUBBLE;
            exmem_halt   = HALT_BUBBLE;
            memwb_halt   = HALT_BUBBLE;
            ifid_discard = 1'b1;
            idex_discard = 1'b1;
            kill_next    = 1'b0;
        end else if (mem_stall_req) begin
            // EX is frozen, so a pending branch is re-presented once memory returns
            pc_hold    = 1'b1;
            ifid_halt  = HALT_HOLD;
            idex_halt  = HALT_HOLD;
            exmem_halt = HALT_HOLD;
            memwb_halt = HALT_BUBBLE;
            stall_sel  = 1'b1;
        end else begin
            if (ex_branch_taken) begin
                pc_redirect  = 1'b1;
                redirect_pc  = ex_branch_target;
                ifid_discard = 1'b1;
                idex_discard = 1'b1;
                ifid_halt    = HALT_BUBBLE;
                idex_halt    = HALT_BUBBLE;
                // A fetch still outstanding belongs to the wrong path
                kill_next    = if_stall_req;
            end else if (id_stall_req) begin
                pc_hold   = 1'b1;
                ifid_halt = HALT_HOLD;
                idex_halt = HALT_BUBBLE;
                stall_sel = 1'b1;
            end else if (if_stall_req) begin
                pc_hold   = 1'b1;
                ifid_halt = HALT_BUBBLE;
                stall_sel = 1'b1;
            end

            // Wrong-path word arrives this cycle: drop it instead of latching it
            if (kill_pend && !if_stall_req) begin
                ifid_discard = 1'b1;
                ifid_halt    = HALT_BUBBLE;
                kill_next    = 1'b0;
            end
        end
    end

    // Wrong-path fetch tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kill_pend <= 1'b0;
        end else begin
            kill_pend <= kill_next;
        end
    end

    // Stall watchdog: saturating counter plus sticky timeout flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt     <= 16'h0;
            stall_timeout <= 1'b0;
        end else if (wd_stall) begin
            if (stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + 16'h1;
            end
            if (stall_cnt >= CNT_MAX - 16'h1) begin
                stall_timeout <= 1'b1;
            end
        end else begin
            stall_cnt <= 16'h0;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    // Free-running event counters, wrap naturally at 32 bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_q <= 32'h0;
            perf_flush_q <= 32'h0;
        end else begin
            if (stall_sel) begin
                perf_stall_q <= perf_stall_q + 32'h1;
            end
            if (pc_redirect) begin
                perf_flush_q <= perf_flush_q + 32'h1;
            end
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flushes      = perf_flush_q;
`else
    assign perf_stall_cycles = 32'h0;
    assign perf_flushes      = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Directed-vector scoreboard bench for pipe_hazard_ctrl.
//                Driver pushes hand-computed expectations, monitor pops and
//                compares once per cycle on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic        ph;
        logic        pr;
        logic [31:0] rpc;
        logic [1:0]  h1;
        logic [1:0]  h2;
        logic [1:0]  h3;
        logic [1:0]  h4;
        logic        d1;
        logic        d2;
        logic        to;
        logic [31:0] ps;
        logic [31:0] pf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_stall_req = 1'b0;
    logic        id_stall_req = 1'b0;
    logic        mem_stall_req = 1'b0;
    logic        ex_branch_taken = 1'b0;
    logic [31:0] ex_branch_target = 32'h0;
    logic        pc_hold;
    logic        pc_redirect;
    logic [31:0] redirect_pc;
    logic [1:0]  ifid_halt;
    logic [1:0]  idex_halt;
    logic [1:0]  exmem_halt;
    logic [1:0]  memwb_halt;
    logic        ifid_discard;
    logic        idex_discard;
    logic        stall_timeout;
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flushes;

    exp_t        exp_q[$];
    string       name_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] mdl_ps = 32'h0;
    logic [31:0] mdl_pf = 32'h0;
    bit          done = 1'b0;

    pipe_hazard_ctrl #(.MAX_STALL(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .if_stall_req      (if_stall_req),
        .id_stall_req      (id_stall_req),
        .mem_stall_req     (mem_stall_req),
        .ex_branch_taken   (ex_branch_taken),
        .ex_branch_target  (ex_branch_target),
        .pc_hold           (pc_hold),
        .pc_redirect       (pc_redirect),
        .redirect_pc       (redirect_pc),
        .ifid_halt         (ifid_halt),
        .idex_halt         (idex_halt),
        .exmem_halt        (exmem_halt),
        .memwb_halt        (memwb_halt),
        .ifid_discard      (ifid_discard),
        .idex_discard      (idex_discard),
        .stall_timeout     (stall_timeout),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flushes      (perf_flushes)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic ph, input logic pr, input logic [31:0] rpc,
                                input logic [1:0] h1, input logic [1:0] h2,
                                input logic [1:0] h3, input logic [1:0] h4,
                                input logic d1, input logic d2, input logic to);
        exp_t e;
        e.ph = ph; e.pr = pr; e.rpc = rpc;
        e.h1 = h1; e.h2 = h2; e.h3 = h3; e.h4 = h4;
        e.d1 = d1; e.d2 = d2; e.to = to;
        e.ps = 32'h0; e.pf = 32'h0;
        return e;
    endfunction

    // Apply one cycle of inputs, queue its expectation, advance past the edge
    task automatic step(input string nm, input logic r, input logic i, input logic d,
                        input logic m, input logic b, input logic [31:0] t, input exp_t e);
        exp_t x;
        x = e;
        rst = r; if_stall_req = i; id_stall_req = d; mem_stall_req = m;
        ex_branch_taken = b; ex_branch_target = t;
`ifdef PIPE_CTRL_PERF_EN
        x.ps = r ? mdl_ps : 32'h0;
        x.pf = r ? mdl_pf : 32'h0;
`endif
        exp_q.push_back(x);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        if (!r) begin
            mdl_ps = 32'h0;
            mdl_pf = 32'h0;
        end else begin
            if (e.ph) mdl_ps = mdl_ps + 32'h1;
            if (e.pr) mdl_pf = mdl_pf + 32'h1;
        end
    endtask

    // Monitor: compare the DUT against the oldest queued expectation each cycle
    always @(negedge clk) begin
        exp_t  e;
        exp_t  got;
        string nm;
        if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            got.ph = pc_hold; got.pr = pc_redirect; got.rpc = redirect_pc;
            got.h1 = ifid_halt; got.h2 = idex_halt; got.h3 = exmem_halt; got.h4 = memwb_halt;
            got.d1 = ifid_discard; got.d2 = idex_discard; got.to = stall_timeout;
            got.ps = perf_stall_cycles; got.pf = perf_flushes;
            total = total + 1;
            if (got !== e) begin
                bad = bad + 1;
                $display("FAIL %s: got ph=%b pr=%b rpc=%h halts=%b/%b/%b/%b disc=%b%b to=%b ps=%h pf=%h ; want ph=%b pr=%b rpc=%h halts=%b/%b/%b/%b disc=%b%b to=%b ps=%h pf=%h",
                         nm, got.ph, got.pr, got.rpc, got.h1, got.h2, got.h3, got.h4, got.d1, got.d2, got.to, got.ps, got.pf,
                         e.ph, e.pr, e.rpc, e.h1, e.h2, e.h3, e.h4, e.d1, e.d2, e.to, e.ps, e.pf);
            end
        end
    end

    initial begin
        exp_t rs, idle, mst, ifs;
        rs   = mk(1, 0, 32'h0, 2'b10, 2'b10, 2'b10, 2'b10, 1, 1, 0);
        idle = mk(0, 0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        mst  = mk(1, 0, 32'h0, 2'b11, 2'b11, 2'b11, 2'b10, 0, 0, 0);
        ifs  = mk(1, 0, 32'h0, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 0);

        @(posedge clk);
        #1;
        // Reset forces bubbles regardless of requests
        step("reset_idle",   0, 0, 0, 0, 0, 32'h0,   rs);
        step("reset_busy",   0, 1, 1, 1, 1, 32'h80,  rs);
        step("idle",         1, 0, 0, 0, 0, 32'h0,   idle);

        // Memory stall masks a branch until it drops
        step("mem_c1",       1, 0, 0, 1, 0, 32'h0,   mst);
        step("mem_c2_br",    1, 0, 0, 1, 1, 32'h100, mst);
        step("mem_c3_br",    1, 0, 0, 1, 1, 32'h100, mst);
        step("mem_c4_redir", 1, 0, 0, 0, 1, 32'h100, mk(0, 1, 32'h100, 2'b10, 2'b10, 2'b00, 2'b00, 1, 1, 0));
        step("mem_after",    1, 0, 0, 0, 0, 32'h0,   idle);

        // Branch during outstanding fetch leaves a wrong-path word to drop
        step("kill_br",      1, 1, 0, 0, 1, 32'h40,  mk(0, 1, 32'h40, 2'b10, 2'b10, 2'b00, 2'b00, 1, 1, 0));
        step("kill_if1",     1, 1, 0, 0, 0, 32'h0,   ifs);
        step("kill_if2",     1, 1, 0, 0, 0, 32'h0,   ifs);
        step("kill_drop",    1, 0, 0, 0, 0, 32'h0,   mk(0, 0, 32'h0, 2'b10, 2'b00, 2'b00, 2'b00, 1, 0, 0));
        step("kill_done",    1, 0, 0, 0, 0, 32'h0,   idle);

        // Load-use stall
        step("id_stall",     1, 0, 1, 0, 0, 32'h0,   mk(1, 0, 32'h0, 2'b11, 2'b10, 2'b00, 2'b00, 0, 0, 0));
        step("id_after",     1, 0, 0, 0, 0, 32'h0,   idle);

        // Reset in the middle of a pending kill clears it
        step("rk_br",        1, 1, 0, 0, 1, 32'h44,  mk(0, 1, 32'h44, 2'b10, 2'b10, 2'b00, 2'b00, 1, 1, 0));
        step("rk_reset",     0, 0, 0, 0, 0, 32'h0,   rs);
        step("rk_no_kill",   1, 0, 0, 0, 0, 32'h0,   idle);

        // Watchdog with MAX_STALL=4
        for (int k = 1; k <= 6; k++) begin
            exp_t w;
            w = ifs;
            w.to = (k >= 5);
            step($sformatf("wd_c%0d", k), 1, 1, 0, 0, 0, 32'h0, w);
        end
        idle.to = 1'b1;
        step("wd_sticky1",   1, 0, 0, 0, 0, 32'h0,   idle);
        step("wd_sticky2",   1, 0, 0, 0, 0, 32'h0,   idle);
        idle.to = 1'b0;
        step("wd_reset",     0, 0, 0, 0, 0, 32'h0,   rs);
        step("wd_cleared",   1, 0, 0, 0, 0, 32'h0,   idle);

        // Stall counter must not trip on an id stall nor on an interrupted run
        for (int k = 1; k <= 5; k++)
            step($sformatf("wd_id_c%0d", k), 1, 0, 1, 0, 0, 32'h0, mk(1, 0, 32'h0, 2'b11, 2'b10, 2'b00, 2'b00, 0, 0, 0));
        step("wd_mem3a",     1, 0, 0, 1, 0, 32'h0,   mst);
        step("wd_mem3b",     1, 0, 0, 1, 0, 32'h0,   mst);
        step("wd_mem3c",     1, 0, 0, 1, 0, 32'h0,   mst);
        step("wd_break",     1, 0, 0, 0, 0, 32'h0,   idle);
        step("wd_mem1",      1, 0, 0, 1, 0, 32'h0,   mst);
        step("wd_no_trip",   1, 0, 0, 0, 0, 32'h0,   idle);

`ifdef PIPE_CTRL_PERF_EN
        // Stall counter wraps from all-ones to zero
        force dut.perf_stall_q = 32'hFFFF_FFFF;
        #1;
        release dut.perf_stall_q;
        mdl_ps = 32'hFFFF_FFFF;
        step("perf_wrap_pre",  1, 1, 0, 0, 0, 32'h0, ifs);
        step("perf_wrap_post", 1, 0, 0, 0, 0, 32'h0, idle);
`endif

        // Let the monitor drain, bounded
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total = total + 1;
            bad = bad + 1;
            $display("FAIL drain: pending=%0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage RV32I core.
- Collects stall requests from IF, ID and MEM, and the taken-branch indication from EX.
- Drives the per-boundary halt codes, the discard strobes and the PC hold/redirect controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Tracks wrong-path fetches still in flight across a redirect, and runs a stall watchdog.

Parameters:
MAX_STALL, 1023, consecutive stall cycles before stall_timeout sets (1..65535)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
if_stall_req  in  1  instruction fetch outstanding
id_stall_req  in  1  load-use hazard in ID
mem_stall_req  in  1  data memory access outstanding
ex_branch_taken  in  1  EX resolved a taken branch/jump this cycle
ex_branch_target  in  32  redirect address
pc_hold  out  1  PC keeps its value
pc_redirect  out  1  PC loads redirect_pc
redirect_pc  out  32  next PC on redirect
ifid_halt  out  2  IF/ID halt code
idex_halt  out  2  ID/EX halt code
exmem_halt  out  2  EX/MEM halt code
memwb_halt  out  2  MEM/WB halt code
ifid_discard  out  1  IF/ID loads NOP
idex_discard  out  1  ID/EX loads NOP
stall_timeout  out  1  sticky watchdog flag
perf_stall_cycles  out  32  cycles with any stall active
perf_flushes  out  32  redirects taken

Behaviour:
- Halt codes: 00 advance; 01 reserved; 10 load bubble; 11 hold contents.
- Outputs are combinational from the inputs plus registered state: zero-cycle reaction.
- State registers: kill_pend, stall_cnt, stall_timeout, perf counters.
- While rst=0: all halts 10, both discards 1, pc_hold 1, pc_redirect 0, redirect_pc 0, kill_pend 0, stall_cnt 0, stall_timeout 0, perf counters 0.
- Asserting rst mid-stall or mid-kill clears all state immediately.
- Per-cycle priority (first match wins):
  1. mem_stall_req: pc_hold=1; ifid/idex/exmem=11; memwb=10. Branch is ignored: EX is frozen and re-presents it. kill_pend is unchanged.
  2. ex_branch_taken: pc_redirect=1; redirect_pc=ex_branch_target; ifid_discard=idex_discard=1; ifid/idex=10; exmem/memwb=00. If if_stall_req=1 this cycle, set kill_pend.
  3. id_stall_req: pc_hold=1; ifid=11; idex=10; exmem/memwb=00.
  4. if_stall_req: pc_hold=1; ifid=10; others 00.
  5. Otherwise all halts 00, all strobes 0.
- When not redirecting, redirect_pc=0.
- kill_pend handling:
  - The first cycle with kill_pend=1, if_stall_req=0 and mem_stall_req=0 forces ifid_discard=1 and ifid=10 to drop the wrong-path word. kill_pend clears at that clock edge.
  - If that cycle also takes a branch, case 2 applies and kill_pend is set only if if_stall_req=1. Since if_stall_req is 0 in that cycle, kill_pend clears.
- Watchdog:
  - stall_cnt increments each cycle with if_stall_req|mem_stall_req and resets to 0 on any cycle without them.
  - stall_cnt saturates at MAX_STALL.
  - On the edge where stall_cnt reaches MAX_STALL, stall_timeout sets and stays set until reset.
  - id_stall_req does not count.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined:
  - perf_stall_cycles increments on every cycle where case 1, 3 or 4 is selected.
  - perf_flushes increments on every cycle with pc_redirect=1.
  - Both are free-running 32-bit counters and wrap 0xFFFFFFFF→0.
- Undefined: both ports are constant 0 and no counter flops exist.

Test Plan:
1. Reset, release rst, drive no requests → all halts 00, discards 0, pc_hold 0; during rst=0 all halts read 10.
2. mem_stall_req=1 for 3 cycles, with ex_branch_taken=1 and target 0x100 in cycle 2 → no redirect during the stall; cycle 4 (stall dropped, branch held) gives pc_redirect=1, redirect_pc=0x100, both discards 1; perf_flushes=1.
3. ex_branch_taken with if_stall_req=1 (target 0x40), if_stall_req held 2 more cycles then dropped → kill_pend set; ifid_discard=1 exactly on the first cycle if_stall_req=0; next cycle ifid_discard=0.
4. id_stall_req=1 for 1 cycle → pc_hold=1, ifid=11, idex=10, exmem=00; the following cycle all 00.
5. MAX_STALL=4, if_stall_req held 6 cycles → stall_timeout rises after the 4th stalled edge and stays 1 after the request drops, until rst=0.
6. PIPE_CTRL_PERF_EN defined, perf_stall_cycles preloaded to 0xFFFFFFFF by force, one stall cycle → counter reads 0; with the macro undefined it reads 0 throughout.
